// File: rtl/alu_pkg.sv
// alu_pkg: shared types and default widths for the ALU command sequencer.
//   alu_op_e    - ALU opcode encoding (ADD..XOR = 0..7)
//   seq_state_e - sequencer FSM states
//   alu_rsp_t   - response entry {result, carry, zero, tag} at default widths
package alu_pkg;

    localparam int OPCODE_WIDTH_DEF = 2;   // opcode MSB index
    localparam int DATA_WIDTH_DEF   = 7;   // operand MSB index
    localparam int ALU_LATENCY_DEF  = 1;
    localparam int RSP_DEPTH_DEF    = 2;
    localparam int TAG_WIDTH_DEF    = 4;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_INC  = 3'd2,
        ALU_DEC  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_NAND = 3'd6,
        ALU_XOR  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [DATA_WIDTH_DEF:0]  result;
        logic                     carry;
        logic                     zero;
        logic [TAG_WIDTH_DEF-1:0] tag;
    } alu_rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous FIFO of response entries.
//   clk, rstn  - clock, asynchronous active-low reset (clears contents)
//   push       - write push_data at the tail (caller guarantees space)
//   push_data  - entry to write
//   pop        - remove head entry; ignored when empty
//   head       - current head entry (stable until popped)
//   count      - number of stored entries
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH   = RSP_DEPTH_DEF,
    parameter type entry_t = alu_rsp_t
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;   // power-of-two depth: natural wrap
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command at a time to a registered ALU, waits
// out its latency, and queues tagged responses.
//   clk, rstn             - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   - command handshake
//   cmd_opcode/op1/op2    - command fields; cmd_chain replaces op1 with the
//                           last captured result
//   alu_opcode/op1/op2    - registered drive into the ALU
//   alu_result/carry/zero - ALU outputs, captured after the latency
//   rsp_valid/rsp_ready   - response handshake; rsp_* show the FIFO head
//   busy                  - a command is in flight
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ALU_LATENCY  = ALU_LATENCY_DEF,
    parameter int RSP_DEPTH    = RSP_DEPTH_DEF,
    parameter int TAG_WIDTH    = TAG_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPCODE_WIDTH:0]   cmd_opcode,
    input  logic [DATA_WIDTH:0]     cmd_op1,
    input  logic [DATA_WIDTH:0]     cmd_op2,
    input  logic                    cmd_chain,
    output logic [OPCODE_WIDTH:0]   alu_opcode,
    output logic [DATA_WIDTH:0]     alu_op1,
    output logic [DATA_WIDTH:0]     alu_op2,
    input  logic [DATA_WIDTH:0]     alu_result,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH:0]     rsp_result,
    output logic                    rsp_carry,
    output logic                    rsp_zero,
    output logic [TAG_WIDTH-1:0]    rsp_tag,
    output logic                    busy
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    // Entry type sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_WIDTH:0]  result;
        logic                 carry;
        logic                 zero;
        logic [TAG_WIDTH-1:0] tag;
    } rsp_entry_t;

    seq_state_e             state_q, state_d;
    logic [OPCODE_WIDTH:0]  alu_opcode_q, alu_opcode_d;
    logic [DATA_WIDTH:0]    alu_op1_q, alu_op1_d;
    logic [DATA_WIDTH:0]    alu_op2_q, alu_op2_d;
    logic [DATA_WIDTH:0]    acc_q, acc_d;
    logic [TAG_WIDTH-1:0]   tag_cnt_q, tag_cnt_d;
    logic [TAG_WIDTH-1:0]   cur_tag_q, cur_tag_d;
    logic [LW-1:0]          lat_cnt_q, lat_cnt_d;

    logic                   accept;
    logic                   capture;
    logic [CW-1:0]          fifo_count;
    rsp_entry_t             push_entry;
    rsp_entry_t             head;

    // Acceptance needs a free FIFO slot; with one command in flight this
    // reserves the slot the capture will later fill. Held low while in reset.
    assign cmd_ready = rstn && (state_q == IDLE) && (fifo_count < CW'(RSP_DEPTH));
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        alu_opcode_d = alu_opcode_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        acc_d        = acc_q;
        tag_cnt_d    = tag_cnt_q;
        cur_tag_d    = cur_tag_q;
        lat_cnt_d    = lat_cnt_q;
        capture      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_opcode_d = cmd_opcode;
                    alu_op1_d    = cmd_chain ? acc_q : cmd_op1;
                    alu_op2_d    = cmd_op2;
                    cur_tag_d    = tag_cnt_q;
                    tag_cnt_d    = tag_cnt_q + 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // ALU samples alu_* on this edge.
                lat_cnt_d = LW'(ALU_LATENCY - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    capture = 1'b1;
                    acc_d   = alu_result;
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_entry        = '0;
        push_entry.result = alu_result;
        push_entry.carry  = alu_carry;
        push_entry.zero   = alu_zero;
        push_entry.tag    = cur_tag_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            alu_opcode_q <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            acc_q        <= '0;
            tag_cnt_q    <= '0;
            cur_tag_q    <= '0;
            lat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            alu_opcode_q <= alu_opcode_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            acc_q        <= acc_d;
            tag_cnt_q    <= tag_cnt_d;
            cur_tag_q    <= cur_tag_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    alu_rsp_fifo #(
        .DEPTH   (RSP_DEPTH),
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (capture),
        .push_data (push_entry),
        .pop       (rsp_ready),
        .head      (head),
        .count     (fifo_count)
    );

    assign alu_opcode = alu_opcode_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign rsp_valid  = (fifo_count != '0);
    assign rsp_result = head.result;
    assign rsp_carry  = head.carry;
    assign rsp_zero   = head.zero;
    assign rsp_tag    = head.tag;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a registered one-cycle ALU alongside it.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_opcode = '0;
    logic [7:0] cmd_op1 = '0, cmd_op2 = '0;
    logic       cmd_chain = 1'b0;
    logic [2:0] alu_opcode;
    logic [7:0] alu_op1, alu_op2;
    logic [7:0] alu_result;
    logic       alu_carry, alu_zero;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_result;
    logic       rsp_carry, rsp_zero;
    logic [3:0] rsp_tag;
    logic       busy;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_chain(cmd_chain),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag), .busy(busy)
    );

    // Arithmetic view of the 8-op ALU: {result[7:0], carry, zero}.
    function automatic logic [9:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int r;
        logic c;
        c = 1'b0;
        case (op)
            3'd0: begin r = int'(a) + int'(b); c = (r > 255); end
            3'd1: begin r = int'(a) - int'(b); c = (r < 0); end
            3'd2: begin r = int'(a) + 1;       c = (r > 255); end
            3'd3: begin r = int'(a) - 1;       c = (r < 0); end
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(~(a & b));
            default: r = int'(a ^ b);
        endcase
        r = ((r % 256) + 256) % 256;
        return {8'(r), c, (r == 0)};
    endfunction

    // ALU instance stand-in: one register stage.
    always_ff @(posedge clk) begin
        {alu_result, alu_carry, alu_zero} <= ref_alu(alu_opcode, alu_op1, alu_op2);
    end

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic [3:0] tag;
    } exp_t;

    exp_t       q[$];
    logic [7:0] exp_acc = '0;
    logic [3:0] exp_tag = '0;
    logic [7:0] last_op1 = '0;
    int         n_asrt = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        exp_acc = '0;
        exp_tag = '0;
    endtask

    task automatic model_accept(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [9:0] r;
        exp_t e;
        r = ref_alu(op, a, b);
        e.res = r[9:2];
        e.c   = r[1];
        e.z   = r[0];
        e.tag = exp_tag;
        q.push_back(e);
        exp_tag = exp_tag + 4'd1;
        exp_acc = r[9:2];
    endtask

    task automatic check_head();
        chk("exp_q_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
            chk("rsp_result", rsp_result, q[0].res);
            chk("rsp_carry", rsp_carry, q[0].c);
            chk("rsp_zero", rsp_zero, q[0].z);
            chk("rsp_tag", rsp_tag, q[0].tag);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
        int n;
        logic [7:0] eop1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_op1    = a;
        cmd_op2    = b;
        cmd_chain  = ch;
        eop1 = ch ? exp_acc : a;
        model_accept(op, eop1, b);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_opcode = 3'($urandom);
        cmd_op1    = 8'($urandom);
        cmd_op2    = 8'($urandom);
        cmd_chain  = 1'($urandom);
        chk("alu_opcode", alu_opcode, op);
        chk("alu_op1", alu_op1, eop1);
        chk("alu_op2", alu_op2, b);
        chk("busy_after_accept", busy, 1);
        last_op1 = eop1;
    endtask

    // Waits for a response (rsp_ready=1), checks it against the model, pops.
    task automatic expect_rsp(output logic [7:0] r, output logic c, output logic z, output logic [3:0] t);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_wait", rsp_valid, 1);
        check_head();
        chk("alu_op1_hold", alu_op1, last_op1);
        r = rsp_result;
        c = rsp_carry;
        z = rsp_zero;
        t = rsp_tag;
        if (q.size() != 0) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu", {alu_opcode, alu_op1, alu_op2}, 0);
        chk("rst_rsp_fields", {rsp_result, rsp_carry, rsp_zero, rsp_tag}, 0);
        rstn = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] r;
    logic       c, z;
    logic [3:0] t;
    logic [7:0] lexp [4];
    logic [2:0] rop;

    initial begin
        lexp[0] = 8'h30; lexp[1] = 8'hFC; lexp[2] = 8'hCF; lexp[3] = 8'hCC;
        #1;
        do_reset();
        chk("idle_ready", cmd_ready, 1);

        // ADD 200,100 with latency profile
        issue(ALU_ADD, 8'd200, 8'd100, 1'b0);
        chk("lat_valid_a0", rsp_valid, 0);
        chk("lat_ready_a0", cmd_ready, 0);
        @(negedge clk);
        chk("lat_valid_a1", rsp_valid, 0);
        chk("lat_busy_a1", busy, 1);
        @(negedge clk);
        chk("lat_valid_a2", rsp_valid, 1);
        chk("lat_ready_a2", cmd_ready, 1);
        chk("lat_busy_a2", busy, 0);
        expect_rsp(r, c, z, t);
        chk("add_const", {r, c, z, t}, {8'd44, 1'b1, 1'b0, 4'd0});

        issue(ALU_SUB, 8'd5, 8'd5, 1'b0);
        expect_rsp(r, c, z, t);
        chk("sub_const", {r, c, z}, {8'd0, 1'b0, 1'b1});

        issue(ALU_DEC, 8'd0, 8'($urandom), 1'b0);
        expect_rsp(r, c, z, t);
        chk("dec_const", {r, c, z}, {8'd255, 1'b1, 1'b0});

        // Chaining from a fresh reset
        do_reset();
        issue(ALU_INC, 8'd255, 8'd0, 1'b0);
        expect_rsp(r, c, z, t);
        chk("inc_const", {r, c, t}, {8'd0, 1'b1, 4'd0});
        issue(ALU_ADD, 8'd99, 8'd7, 1'b1);
        chk("chain_op1_const", alu_op1, 0);
        expect_rsp(r, c, z, t);
        chk("chain_const", {r, t}, {8'd7, 4'd1});

        // Logic ops
        for (int i = 0; i < 4; i++) begin
            rop = 3'(4 + i);
            issue(rop, 8'hF0, 8'h3C, 1'b0);
            expect_rsp(r, c, z, t);
            chk("logic_const", r, lexp[i]);
        end

        // Backpressure: two fill the FIFO, third waits
        rsp_ready = 1'b0;
        issue(ALU_ADD, 8'd10, 8'd20, 1'b0);
        issue(ALU_XOR, 8'h55, 8'h0F, 1'b0);
        repeat (3) @(negedge clk);
        chk("bp_valid", rsp_valid, 1);
        chk("bp_ready_low", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_opcode = ALU_SUB; cmd_op1 = 8'd50; cmd_op2 = 8'd8; cmd_chain = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_held", cmd_ready, 0);
            chk("bp_not_busy", busy, 0);
            check_head();
        end
        rsp_ready = 1'b1;
        void'(q.pop_front());
        @(negedge clk);
        check_head();
        chk("bp_ready_back", cmd_ready, 1);
        model_accept(ALU_SUB, 8'd50, 8'd8);
        void'(q.pop_front());
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_third_op1", alu_op1, 50);
        last_op1 = 8'd50;
        expect_rsp(r, c, z, t);
        chk("bp_third_result", r, 42);

        // Tag wrap with random commands
        do_reset();
        for (int i = 0; i < 17; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(3'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
            expect_rsp(r, c, z, t);
            if (i == 15) chk("tag_15", t, 15);
            if (i == 16) chk("tag_wrap", t, 0);
        end

        // More random traffic with random rsp_ready stalls
        for (int i = 0; i < 20; i++) begin
            issue(3'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0));
            rsp_ready = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            rsp_ready = 1'b1;
            expect_rsp(r, c, z, t);
        end

        // Reset while in WAIT with a response still queued
        rsp_ready = 1'b0;
        issue(ALU_ADD, 8'd1, 8'd2, 1'b0);
        issue(ALU_ADD, 8'd3, 8'd4, 1'b0);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_alu", {alu_opcode, alu_op1, alu_op2}, 0);
        chk("mid_busy_clr", busy, 0);
        chk("mid_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        rsp_ready = 1'b1;
        model_clear();
        @(negedge clk);
        issue(ALU_ADD, 8'd99, 8'd5, 1'b1);
        chk("post_rst_acc", alu_op1, 0);
        expect_rsp(r, c, z, t);
        chk("post_rst_rsp", {r, t}, {8'd5, 4'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
